grant_decoder_fifo: RTL and testbench

- Consumer end of the 3-channel one-hot priority-grant path: takes the one-hot grant vector produced by the priority encoder stage and decodes it back to a binary channel index.
- Buffers decoded indices in a small FIFO behind a valid/ready handshake.
- Keeps per-channel saturating grant counters.
- Flags illegal (multi-hot) grant vectors with a sticky error.

---
 rtl/grant_pkg.sv | 17 +
 rtl/onehot_to_idx.sv | 35 +++
 rtl/grant_decoder_fifo.sv | 122 ++++++++++++
 tb/tb_grant_decoder_fifo.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/grant_pkg.sv
// rtl/grant_pkg.sv - shared defaults, channel constants and grant classification type
package grant_pkg;

    localparam int NUM_CH_DEF = 3;
    localparam int IDX_W_DEF  = 2;

    localparam logic [IDX_W_DEF-1:0] CH0 = 2'd0;
    localparam logic [IDX_W_DEF-1:0] CH1 = 2'd1;
    localparam logic [IDX_W_DEF-1:0] CH2 = 2'd2;

    typedef enum logic [1:0] {
        GR_NONE   = 2'd0,
        GR_ONEHOT = 2'd1,
        GR_MULTI  = 2'd2
    } grant_class_e;

endpackage

// File: rtl/onehot_to_idx.sv
// rtl/onehot_to_idx.sv - combinational one-hot grant to binary index decoder with classification
module onehot_to_idx
    import grant_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int IDX_W  = IDX_W_DEF
) (
    input  logic [NUM_CH-1:0] i_grant,
    output logic [IDX_W-1:0]  o_idx,
    output grant_class_e      o_cls
);

    logic [3:0] w_ones;

    // Count set bits and report the highest set bit's index; for a legal
    // one-hot vector that is simply the granted channel.
    always_comb begin
        w_ones = '0;
        o_idx  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (i_grant[i]) begin
                w_ones = w_ones + 4'd1;
                o_idx  = IDX_W'(i);
            end
        end
        if (w_ones == 4'd0) begin
            o_cls = GR_NONE;
        end else if (w_ones == 4'd1) begin
            o_cls = GR_ONEHOT;
        end else begin
            o_cls = GR_MULTI;
        end
    end

endmodule

// File: rtl/grant_decoder_fifo.sv
// rtl/grant_decoder_fifo.sv - grant vector decoder with index FIFO, saturating counters and multi-hot error
module grant_decoder_fifo
    import grant_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int IDX_W  = IDX_W_DEF,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] grant_in,
    input  logic              grant_valid,
    output logic              grant_ready,
    output logic [IDX_W-1:0]  idx_out,
    output logic              idx_valid,
    input  logic              idx_ready,
    output logic              err_multi,
    input  logic              err_clr,
    input  logic [IDX_W-1:0]  cnt_sel,
    output logic [CNT_W-1:0]  cnt_out,
    input  logic              cnt_clr
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [IDX_W-1:0]  r_mem [DEPTH];
    logic [CNT_W-1:0]  r_cnt [NUM_CH];
    logic              r_err;

    logic [IDX_W-1:0]  w_idx;
    grant_class_e      w_cls;
    logic              w_full;
    logic              w_empty;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;

    onehot_to_idx #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_dec (
        .i_grant (grant_in),
        .o_idx   (w_idx),
        .o_cls   (w_cls)
    );

    // Same address with differing wrap bits means the writer lapped the reader.
    assign w_full   = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_empty  = (r_wr_ptr == r_rd_ptr);

    // Ready depends only on registered pointers, never on idx_ready.
    assign grant_ready = !w_full;
    assign w_accept    = grant_valid && grant_ready;
    assign w_push      = w_accept && (w_cls == GR_ONEHOT);
    assign idx_valid   = !w_empty;
    assign w_pop       = idx_valid && idx_ready;
    assign idx_out     = r_mem[r_rd_ptr[AW-1:0]];
    assign err_multi   = r_err;

    // FIFO storage and pointers; storage is reset so idx_out never shows X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= w_idx;
                r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Per-channel saturating grant counters; clear beats a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (cnt_clr) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (w_push) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if ((w_idx == IDX_W'(i)) && (r_cnt[i] != {CNT_W{1'b1}})) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Sticky multi-hot flag; a new illegal grant outranks a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_accept && (w_cls == GR_MULTI)) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    // Counter read mux; selects beyond the channel count read as zero.
    always_comb begin
        cnt_out = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cnt_sel == IDX_W'(i)) begin
                cnt_out = r_cnt[i];
            end
        end
    end

endmodule

// File: tb/tb_grant_decoder_fifo.sv
// tb/tb_grant_decoder_fifo.sv - self-checking bench for grant_decoder_fifo
module tb_grant_decoder_fifo;

    logic       clk;
    logic       rst;
    logic [2:0] grant_in;
    logic       grant_valid;
    logic       grant_ready;
    logic [1:0] idx_out;
    logic       idx_valid;
    logic       idx_ready;
    logic       err_multi;
    logic       err_clr;
    logic [1:0] cnt_sel;
    logic [7:0] cnt_out;
    logic       cnt_clr;

    int n_total = 0;
    int n_pass  = 0;

    grant_decoder_fifo #(
        .NUM_CH (3),
        .IDX_W  (2),
        .DEPTH  (2),
        .CNT_W  (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .grant_in    (grant_in),
        .grant_valid (grant_valid),
        .grant_ready (grant_ready),
        .idx_out     (idx_out),
        .idx_valid   (idx_valid),
        .idx_ready   (idx_ready),
        .err_multi   (err_multi),
        .err_clr     (err_clr),
        .cnt_sel     (cnt_sel),
        .cnt_out     (cnt_out),
        .cnt_clr     (cnt_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] gi;
        logic       gv;
        logic       ir;
        logic       ec;
        logic       cc;
        logic [1:0] sel;
        logic       e_gr;
        logic       e_iv;
        logic [1:0] e_io;
        logic       e_err;
        logic [7:0] e_cnt;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic gr, input logic iv, input logic [1:0] io,
                           input logic er, input logic [7:0] cn);
        chk({tag, ".grant_ready"}, 32'(grant_ready), 32'(gr));
        chk({tag, ".idx_valid"},   32'(idx_valid),   32'(iv));
        chk({tag, ".idx_out"},     32'(idx_out),     32'(io));
        chk({tag, ".err_multi"},   32'(err_multi),   32'(er));
        chk({tag, ".cnt_out"},     32'(cnt_out),     32'(cn));
    endtask

    initial begin
        //            gi     gv   ir   ec   cc   sel   gr   iv   io   err  cnt
        vecs[0]  = '{3'b100,1'b1,1'b1,1'b0,1'b0,2'd2,1'b1,1'b1,2'd2,1'b0,8'd1};
        vecs[1]  = '{3'b000,1'b0,1'b1,1'b0,1'b0,2'd2,1'b1,1'b0,2'd0,1'b0,8'd1};
        vecs[2]  = '{3'b001,1'b1,1'b0,1'b0,1'b0,2'd0,1'b1,1'b1,2'd0,1'b0,8'd1};
        vecs[3]  = '{3'b010,1'b1,1'b0,1'b0,1'b0,2'd1,1'b0,1'b1,2'd0,1'b0,8'd1};
        vecs[4]  = '{3'b100,1'b1,1'b0,1'b0,1'b0,2'd2,1'b0,1'b1,2'd0,1'b0,8'd1};
        vecs[5]  = '{3'b100,1'b1,1'b1,1'b0,1'b0,2'd2,1'b1,1'b1,2'd1,1'b0,8'd1};
        vecs[6]  = '{3'b100,1'b1,1'b0,1'b0,1'b0,2'd2,1'b0,1'b1,2'd1,1'b0,8'd2};
        vecs[7]  = '{3'b000,1'b0,1'b1,1'b0,1'b0,2'd2,1'b1,1'b1,2'd2,1'b0,8'd2};
        vecs[8]  = '{3'b000,1'b0,1'b1,1'b0,1'b0,2'd2,1'b1,1'b0,2'd1,1'b0,8'd2};
        vecs[9]  = '{3'b110,1'b1,1'b1,1'b0,1'b0,2'd1,1'b1,1'b0,2'd1,1'b1,8'd1};
        vecs[10] = '{3'b000,1'b0,1'b1,1'b0,1'b0,2'd1,1'b1,1'b0,2'd1,1'b1,8'd1};
        vecs[11] = '{3'b011,1'b1,1'b1,1'b1,1'b0,2'd1,1'b1,1'b0,2'd1,1'b1,8'd1};
        vecs[12] = '{3'b000,1'b0,1'b1,1'b1,1'b0,2'd1,1'b1,1'b0,2'd1,1'b0,8'd1};
        vecs[13] = '{3'b000,1'b1,1'b1,1'b0,1'b0,2'd1,1'b1,1'b0,2'd1,1'b0,8'd1};
        vecs[14] = '{3'b000,1'b0,1'b1,1'b0,1'b0,2'd3,1'b1,1'b0,2'd1,1'b0,8'd0};
        vecs[15] = '{3'b000,1'b0,1'b1,1'b0,1'b0,2'd0,1'b1,1'b0,2'd1,1'b0,8'd1};

        rst = 1'b1; grant_in = '0; grant_valid = 1'b0; idx_ready = 1'b0;
        err_clr = 1'b0; cnt_clr = 1'b0; cnt_sel = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_all("reset", 1'b1, 1'b0, 2'd0, 1'b0, 8'd0);

        // Directed table: inputs applied at negedge, outputs checked just after the next rising edge.
        for (int v = 0; v < NV; v++) begin
            @(negedge clk);
            grant_in = vecs[v].gi; grant_valid = vecs[v].gv; idx_ready = vecs[v].ir;
            err_clr = vecs[v].ec; cnt_clr = vecs[v].cc; cnt_sel = vecs[v].sel;
            if (v == 0) begin
                #1;
                chk("no_bypass", 32'(idx_valid), 32'd0);
            end
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", v), vecs[v].e_gr, vecs[v].e_iv, vecs[v].e_io,
                    vecs[v].e_err, vecs[v].e_cnt);
        end

        // Saturation: channel 1 counter starts at 1, 300 more grants pin it at 255.
        @(negedge clk);
        grant_in = 3'b010; grant_valid = 1'b1; idx_ready = 1'b1; cnt_sel = 2'd1;
        err_clr = 1'b0; cnt_clr = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk);
            #1;
            if (k == 100) chk("cnt_mid", 32'(cnt_out), 32'd101);
        end
        chk("cnt_sat", 32'(cnt_out), 32'd255);
        chk("sat_ready", 32'(grant_ready), 32'd1);
        chk("sat_idx", 32'(idx_out), 32'd1);
        @(negedge clk);
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        chk("cnt_clr_wins", 32'(cnt_out), 32'd0);
        @(negedge clk);
        cnt_clr = 1'b0;
        @(posedge clk);
        #1;
        chk("cnt_after_clr", 32'(cnt_out), 32'd1);

        // Drain, then fill the FIFO and hit it with an asynchronous reset.
        @(negedge clk);
        grant_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("drained", 32'(idx_valid), 32'd0);
        @(negedge clk);
        idx_ready = 1'b0; grant_valid = 1'b1; grant_in = 3'b001; cnt_sel = 2'd0;
        @(negedge clk);
        grant_in = 3'b100;
        @(posedge clk);
        #1;
        chk("pre_rst_full", 32'(grant_ready), 32'd0);
        chk("pre_rst_valid", 32'(idx_valid), 32'd1);
        chk("pre_rst_cnt0", 32'(cnt_out), 32'd1);
        grant_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 1'b1, 1'b0, 2'd0, 1'b0, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        grant_in = 3'b010; grant_valid = 1'b1; idx_ready = 1'b1; cnt_sel = 2'd1;
        @(posedge clk);
        #1;
        chk("post_rst_idx", 32'(idx_out), 32'd1);
        chk("post_rst_valid", 32'(idx_valid), 32'd1);
        chk("post_rst_cnt1", 32'(cnt_out), 32'd1);
        @(negedge clk);
        grant_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
